// File: rtl/g3f_monitor_if.sv
// g3f_monitor_if: phase inputs, clear and decoded status outputs of the g3f receive-side monitor.
interface g3f_monitor_if;
  logic       qa;
  logic       qb;
  logic       qc;
  logic       clr;
  logic       step;
  logic       dir;
  logic       locked;
  logic       fault;
  logic       stalled;
  logic [7:0] step_cnt;
  modport master (output qa, qb, qc, clr, input step, dir, locked, fault, stalled, step_cnt);
  modport slave  (input qa, qb, qc, clr, output step, dir, locked, fault, stalled, step_cnt);
endinterface

// File: rtl/g3f_monitor.sv
// g3f_monitor: synchronises three-phase g3f lines, decodes direction/lock/position and flags faults and stalls.
module g3f_monitor #(
  parameter int          SYNC_STAGES = 2,
  parameter int          LOCK_COUNT  = 6,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  g3f_monitor_if.slave bus
);
  typedef enum logic {ACQ, LOCKED} state_t;
  localparam int PW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] r_sa, r_sb, r_sc;
  logic [PW-1:0]          r_prime;
  logic [2:0]             r_prev;
  logic                   r_have, r_step, r_dir, r_fault, r_stalled;
  logic [7:0]             r_cnt;
  logic [15:0]            r_idle;
  logic [3:0]             r_run;
  state_t                 r_state;
  logic [2:0]             w_s, w_idx, w_inc, w_dec;
  logic                   w_vld, w_primed, w_fwd, w_rev, w_step, w_flt, w_stall, w_dir;
  logic [15:0]            w_idle;
  logic [3:0]             w_run;
  state_t                 w_state;
  always_comb begin
    w_s      = {r_sa[SYNC_STAGES-1], r_sb[SYNC_STAGES-1], r_sc[SYNC_STAGES-1]};
    w_vld    = (w_s != 3'b000) && (w_s != 3'b111);
    w_idx    = (w_s == 3'b100) ? 3'd0 : (w_s == 3'b110) ? 3'd1 : (w_s == 3'b010) ? 3'd2 :
               (w_s == 3'b011) ? 3'd3 : (w_s == 3'b001) ? 3'd4 : 3'd5;
    w_primed = r_prime == PW'(SYNC_STAGES + 1);
    w_inc    = (r_prev == 3'd5) ? 3'd0 : r_prev + 3'd1;
    w_dec    = (r_prev == 3'd0) ? 3'd5 : r_prev - 3'd1;
    w_fwd    = w_primed && r_have && w_vld && (w_idx == w_inc);
    w_rev    = w_primed && r_have && w_vld && (w_idx == w_dec);
    w_step   = w_fwd || w_rev;
    // a code that is neither a hold nor a neighbour means a state was skipped
    w_flt    = w_primed && (!w_vld || (r_have && (w_idx != r_prev) && !w_step));
    w_idle   = w_step ? 16'd0 : (r_idle == TIMEOUT) ? r_idle : r_idle + 16'd1;
    w_stall  = w_idle == TIMEOUT;
  end
  always_comb begin
    w_state = r_state;
    w_run   = r_run;
    w_dir   = r_dir;
    if (r_state == ACQ) begin
      if (w_flt) w_run = 4'd0;
      else if (w_step) begin
        w_run = (r_run != 4'd0 && w_fwd == r_dir) ? r_run + 4'd1 : 4'd1;
        w_dir = w_fwd;
        if (w_run == 4'(LOCK_COUNT)) w_state = LOCKED;
      end
    end else if (w_flt || w_stall) begin
      w_state = ACQ;
      w_run   = 4'd0;
    end else if (w_step && w_fwd != r_dir) begin
      w_state = ACQ;
      w_run   = 4'd1;
      w_dir   = w_fwd;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa      <= '0;
      r_sb      <= '0;
      r_sc      <= '0;
      r_prime   <= '0;
      r_prev    <= 3'd0;
      r_have    <= 1'b0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_fault   <= 1'b0;
      r_stalled <= 1'b0;
      r_cnt     <= 8'd0;
      r_idle    <= 16'd0;
      r_run     <= 4'd0;
      r_state   <= ACQ;
    end else begin
      r_sa      <= {r_sa[SYNC_STAGES-2:0], bus.qa};
      r_sb      <= {r_sb[SYNC_STAGES-2:0], bus.qb};
      r_sc      <= {r_sc[SYNC_STAGES-2:0], bus.qc};
      r_prime   <= w_primed ? r_prime : r_prime + 1'b1;
      r_prev    <= (w_primed && w_vld) ? w_idx : r_prev;
      r_have    <= r_have || (w_primed && w_vld);
      r_step    <= w_step;
      r_dir     <= w_dir;
      r_fault   <= w_flt || (r_fault && !bus.clr);
      r_stalled <= w_stall;
      r_cnt     <= bus.clr ? 8'd0 : w_fwd ? r_cnt + 8'd1 : w_rev ? r_cnt - 8'd1 : r_cnt;
      r_idle    <= w_idle;
      r_run     <= w_run;
      r_state   <= w_state;
    end
  end
  assign bus.step     = r_step;
  assign bus.dir      = r_dir;
  assign bus.locked   = r_state == LOCKED;
  assign bus.fault    = r_fault;
  assign bus.stalled  = r_stalled;
  assign bus.step_cnt = r_cnt;
endmodule

// File: tb/tb_g3f_monitor.sv
// tb_g3f_monitor: directed-vector bench for g3f_monitor with hand-computed expectations.
module tb_g3f_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0, n_err = 0, steps = 0, p = 0, s0 = 0;
  logic [2:0] codes [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  g3f_monitor_if bus();
  g3f_monitor #(.SYNC_STAGES(2), .LOCK_COUNT(6), .TIMEOUT(16'd20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.step === 1'b1) steps++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int d);
    p = (p + d + 6) % 6;
    {bus.qa, bus.qb, bus.qc} = codes[p];
  endtask
  task automatic go(input int d, input int hold, input bit ck);
    put(d);
    repeat (3) tick();
    if (ck) check("step", bus.step, 1);
    repeat (hold - 3) tick();
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_step"}, bus.step, 0);
    check({tag, "_dir"}, bus.dir, 0);
    check({tag, "_locked"}, bus.locked, 0);
    check({tag, "_fault"}, bus.fault, 0);
    check({tag, "_stalled"}, bus.stalled, 0);
    check({tag, "_cnt"}, bus.step_cnt, 0);
  endtask
  initial begin
    bus.clr = 1'b0;
    {bus.qa, bus.qb, bus.qc} = codes[0];
    repeat (3) tick();
    all_zero("reset");
    rst = 1'b0;
    repeat (10) tick();
    check("prime_fault", bus.fault, 0);
    check("prime_steps", steps, 0);
    // forward lock: 8 steps, lock on the 6th
    for (int k = 1; k <= 8; k++) begin
      put(1);
      repeat (3) tick();
      check("fwd_step", bus.step, 1);
      check("fwd_lock", bus.locked, (k >= 6) ? 1 : 0);
      repeat (7) tick();
    end
    check("fwd_cnt", bus.step_cnt, 8);
    check("fwd_dir", bus.dir, 1);
    check("fwd_fault", bus.fault, 0);
    check("fwd_steps", steps, 8);
    // reversal after lock
    for (int k = 1; k <= 6; k++) begin
      put(-1);
      repeat (3) tick();
      check("rev_step", bus.step, 1);
      if (k == 1) check("rev_unlock", bus.locked, 0);
      repeat (7) tick();
      if (k == 3) begin
        check("rev3_cnt", bus.step_cnt, 5);
        check("rev3_locked", bus.locked, 0);
      end
    end
    check("rev6_locked", bus.locked, 1);
    check("rev6_dir", bus.dir, 0);
    check("rev6_cnt", bus.step_cnt, 2);
    // invalid code, clear, then a skipped state
    {bus.qa, bus.qb, bus.qc} = 3'b111;
    repeat (5) tick();
    check("inv_fault", bus.fault, 1);
    check("inv_locked", bus.locked, 0);
    {bus.qa, bus.qb, bus.qc} = codes[p];
    repeat (5) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_fault", bus.fault, 0);
    check("clr_cnt", bus.step_cnt, 0);
    go(-1, 5, 1);
    go(-1, 5, 1);
    check("pre_jump_fault", bus.fault, 0);
    s0 = steps;
    put(2);
    repeat (5) tick();
    check("jump_fault", bus.fault, 1);
    check("jump_nostep", steps, s0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr2_cnt", bus.step_cnt, 0);
    check("clr2_fault", bus.fault, 0);
    // wrap-around: 257 reverse steps from 0
    repeat (257) go(-1, 4, 0);
    check("wrap_cnt", bus.step_cnt, 255);
    check("wrap_locked", bus.locked, 1);
    check("wrap_dir", bus.dir, 0);
    // stall: lock forward and hold
    for (int k = 1; k <= 5; k++) go(1, 10, 1);
    put(1);
    repeat (3) tick();
    check("stl_step", bus.step, 1);
    check("stl_locked", bus.locked, 1);
    check("stl_dir", bus.dir, 1);
    repeat (19) tick();
    check("stl19_stalled", bus.stalled, 0);
    check("stl19_locked", bus.locked, 1);
    tick();
    check("stl20_stalled", bus.stalled, 1);
    check("stl20_locked", bus.locked, 0);
    put(1);
    repeat (3) tick();
    check("unstall_step", bus.step, 1);
    check("unstall_stalled", bus.stalled, 0);
    // mid-run asynchronous reset
    go(1, 10, 1);
    put(1);
    tick();
    #2 rst = 1'b1;
    #1 all_zero("arst");
    s0 = steps;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("reprime_fault", bus.fault, 0);
    check("reprime_steps", steps, s0);
    go(1, 10, 1);
    check("post_cnt", bus.step_cnt, 1);
    // clr coinciding with a forward step
    put(1);
    repeat (2) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("coll_step", bus.step, 1);
    check("coll_cnt", bus.step_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
